pattern_scheduler: RTL and testbench
====================================

# pattern_scheduler

Frame-synchronous pattern sequencer for the LVDS panel pattern generator. It selects which test pattern the generator draws and changes the selection only on a detected vsync rising edge, so a frame never shows a partial pattern. It supports auto-advance with a programmable dwell in frames, a hold mode, and manual next/previous stepping. It sits between the operator controls and the pattern datapath, in the pixel-clock domain.

## Interface
- NUM_PATTERNS, 8: number of selectable patterns; must be ≥ 2.
- DWELL_W, 10: width of the dwell and frame counters.
- PAT_W, $clog2(NUM_PATTERNS): width of the pattern index (derived).

- iclk  in  1  pixel clock.
- irst  in  1  reset: synchronous, active-low.
- ivsync  in  1  vsync from the timing generator; already in the iclk domain.
- iauto  in  1  1 = auto-advance, 0 = manual.
- ihold  in  1  in auto mode, freezes the dwell count and pattern.
- inext  in  1  one-cycle request: step to the next pattern.
- iprev  in  1  one-cycle request: step to the previous pattern.
- idwell  in  DWELL_W  frames per pattern in auto mode; 0 is treated as 1.
- oPattern  out  PAT_W  current pattern index.
- oFrameStart  out  1  one-cycle pulse per detected frame boundary.
- oDwellCnt  out  DWELL_W  frames elapsed on the current pattern.
- oPending  out  1  a manual step is latched and waiting for the next boundary.

## Operation
- **Edge detect.** A 2-bit shift register `sr <= {sr[0], ivsync}`. Boundary `fb = (sr == 2'b01)`. `sr` resets to 2'b11, so ivsync being high at reset release does not produce a boundary.
- **Mode state.** States are S_MANUAL, S_RUN and S_HOLD.
  - The state is re-evaluated only when fb is high: iauto=0 selects S_MANUAL; iauto=1 with ihold=0 selects S_RUN; iauto=1 with ihold=1 selects S_HOLD.
  - Between boundaries the state is held.
  - The new state governs the following frame.
- **Request latch.**
  - inext and iprev are captured into a 2-bit pending register in every state.
  - A later request overwrites an earlier one.
  - inext and iprev asserted in the same cycle: both are ignored and the pending value is unchanged.
- **Actions on fb, in priority order:**
  1. A pending request, or a request arriving in the same cycle as fb, applies the step, clears pending and sets the dwell count to 0. This holds in any state.
  2. Otherwise, in S_RUN: if `oDwellCnt >= max(idwell,1) - 1`, advance to the next pattern and set the count to 0; else increment the count.
  3. Otherwise, in S_HOLD: the pattern and count are unchanged.
  4. Otherwise, in S_MANUAL: the count saturates at its all-ones value.
- **Wrap-around.** next from NUM_PATTERNS-1 goes to 0; prev from 0 goes to NUM_PATTERNS-1.
- **idwell changes mid-pattern** take effect immediately. Because the comparison is ≥, lowering idwell below the current count advances on the next boundary.

## Timing
- **Reset values:** oPattern=0, oFrameStart=0, oDwellCnt=0, oPending=0, state=S_MANUAL, pending=none, sr=2'b11.
- **Reset mid-operation:** all of the above take effect at the next edge; a pending step is discarded.
- **Boundary latency:**
  - ivsync is first sampled high at edge k.
  - fb is high between edges k and k+1.
  - oPattern, oDwellCnt and oFrameStart update at edge k+1; oFrameStart is high for exactly one cycle.
- **Requests:** oPending rises one cycle after inext/iprev and falls at the boundary edge that applies the step. A request arriving in the same cycle as fb applies at that edge, and oPending stays 0.
- ivsync held high produces one boundary only; a new boundary requires ivsync to go low first.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `pattern_sched_pkg`:**
  - the state enum (S_MANUAL, S_RUN, S_HOLD);
  - the request encoding (REQ_NONE, REQ_NEXT, REQ_PREV);
  - the default NUM_PATTERNS and DWELL_W constants.
- **Sub-module `vsync_edge_det`:** the shift register with set-to-11 reset, producing fb. It is reused by other frame-locked blocks.
- The remaining logic (mode FSM, request latch, dwell counter, index wrap) stays in one module.

## Test plan
All scenarios use NUM_PATTERNS=8.
- **Auto run:** iauto=1, ihold=0, idwell=3, 10 frames → oPattern 0,0,0,1,1,1,2,2,2,3; oDwellCnt cycles 0,1,2.
- **Wrap and dwell 0:** idwell=0 in auto mode starting at pattern 6 → one step per frame: 7, 0, 1.
- **Manual steps:** iauto=0 at pattern 0. Pulse iprev mid-frame: oPending=1, and the next boundary gives oPattern=7, oPending=0. Pulse inext and iprev in the same cycle → no change.
- **Hold with override:** auto mode, idwell=3, count at 1, ihold=1 for 4 frames → pattern and count frozen. Pulse inext during the hold → pattern+1, count=0 at the next boundary.
- **Boundary corner cases:**
  - inext in the same cycle as fb → applied at that edge, oPending never rises.
  - ivsync held high for 3 frame times → one oFrameStart only.
- **Reset:**
  - ivsync=1 at reset release → no oFrameStart until ivsync goes low then high.
  - Reset asserted with a step pending → oPattern=0 and oPending=0 one edge later.

Source files
------------

// File: rtl/pattern_sched_pkg.sv
// Shared types and default sizes for the frame-synchronous pattern scheduler.
package pattern_sched_pkg;

  localparam int unsigned NUM_PATTERNS_DEF = 8;
  localparam int unsigned DWELL_W_DEF      = 10;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_RUN    = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_NEXT = 2'b01,
    REQ_PREV = 2'b10
  } req_e;

endpackage

// File: rtl/vsync_edge_det.sv
// Vsync rising-edge detector; history resets to 11 so a vsync already high
// at reset release is not mistaken for a new frame boundary.
module vsync_edge_det (
  input  logic iclk,
  input  logic irst,
  input  logic ivsync,
  output logic oFrameBoundary
);

  logic [1:0] sr_q;

  always_ff @(posedge iclk) begin
    if (!irst) begin
      sr_q <= 2'b11;
    end else begin
      sr_q <= {sr_q[0], ivsync};
    end
  end

  assign oFrameBoundary = (sr_q == 2'b01);

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-locked test-pattern selector: auto-advance with dwell, hold, and
// manual next/prev stepping, all applied only on a vsync rising edge.
module pattern_scheduler
  import pattern_sched_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = NUM_PATTERNS_DEF,
  parameter int unsigned DWELL_W      = DWELL_W_DEF,
  // Derived; leave at default.
  parameter int unsigned PAT_W        = $clog2(NUM_PATTERNS)
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               ivsync,
  input  logic               iauto,
  input  logic               ihold,
  input  logic               inext,
  input  logic               iprev,
  input  logic [DWELL_W-1:0] idwell,
  output logic [PAT_W-1:0]   oPattern,
  output logic               oFrameStart,
  output logic [DWELL_W-1:0] oDwellCnt,
  output logic               oPending
);

  localparam logic [PAT_W-1:0]   LastPat = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [DWELL_W-1:0] CntMax  = '1;

  logic fb;

  vsync_edge_det u_edge_det (
    .iclk           (iclk),
    .irst           (irst),
    .ivsync         (ivsync),
    .oFrameBoundary (fb)
  );

  state_e             state_q, state_d;
  req_e               pend_q, pend_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               fs_q, fs_d;

  req_e               req_in, req_eff;
  logic [PAT_W-1:0]   pat_next, pat_prev;
  logic [DWELL_W-1:0] dwell_last;

  // Simultaneous next+prev cancels out and leaves the latch untouched.
  always_comb begin
    req_in = REQ_NONE;
    if (inext && !iprev) begin
      req_in = REQ_NEXT;
    end else if (iprev && !inext) begin
      req_in = REQ_PREV;
    end
  end

  assign req_eff    = (req_in != REQ_NONE) ? req_in : pend_q;
  assign pat_next   = (pat_q == LastPat) ? '0 : pat_q + PAT_W'(1);
  assign pat_prev   = (pat_q == '0) ? LastPat : pat_q - PAT_W'(1);
  assign dwell_last = (idwell == '0) ? '0 : idwell - DWELL_W'(1);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    fs_d    = fb;

    if (!fb) begin
      if (req_in != REQ_NONE) begin
        pend_d = req_in;
      end
    end else begin
      if (!iauto) begin
        state_d = S_MANUAL;
      end else if (ihold) begin
        state_d = S_HOLD;
      end else begin
        state_d = S_RUN;
      end
      pend_d = REQ_NONE;

      // Manual steps win in every mode; otherwise the mode of the ending frame decides.
      if (req_eff == REQ_NEXT) begin
        pat_d = pat_next;
        cnt_d = '0;
      end else if (req_eff == REQ_PREV) begin
        pat_d = pat_prev;
        cnt_d = '0;
      end else begin
        case (state_q)
          S_RUN: begin
            if (cnt_q >= dwell_last) begin
              pat_d = pat_next;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + DWELL_W'(1);
            end
          end
          S_HOLD: begin
            cnt_d = cnt_q;
          end
          default: begin
            if (cnt_q != CntMax) begin
              cnt_d = cnt_q + DWELL_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_q <= S_MANUAL;
      pend_q  <= REQ_NONE;
      pat_q   <= '0;
      cnt_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
    end
  end

  assign oPattern    = pat_q;
  assign oFrameStart = fs_q;
  assign oDwellCnt   = cnt_q;
  assign oPending    = (pend_q != REQ_NONE);

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed-vector bench for pattern_scheduler with hand-computed expectations.
module tb_pattern_scheduler;

  logic       iclk = 1'b0;
  logic       irst;
  logic       ivsync;
  logic       iauto;
  logic       ihold;
  logic       inext;
  logic       iprev;
  logic [9:0] idwell;
  logic [2:0] oPattern;
  logic       oFrameStart;
  logic [9:0] oDwellCnt;
  logic       oPending;

  int n_vec = 0;
  int n_err = 0;

  pattern_scheduler dut (
    .iclk        (iclk),
    .irst        (irst),
    .ivsync      (ivsync),
    .iauto       (iauto),
    .ihold       (ihold),
    .inext       (inext),
    .iprev       (iprev),
    .idwell      (idwell),
    .oPattern    (oPattern),
    .oFrameStart (oFrameStart),
    .oDwellCnt   (oDwellCnt),
    .oPending    (oPending)
  );

  always #5 iclk = ~iclk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One vsync rising edge; nx/pv are driven during the cycle fb is high.
  task automatic frame(input logic nx, input logic pv, input int exp_pat, input int exp_cnt,
                       input string tag);
    ivsync = 1'b1;
    @(posedge iclk); #1;
    check_eq({tag, ".fs_early"}, int'(oFrameStart), 0);
    inext = nx;
    iprev = pv;
    @(posedge iclk); #1;
    inext = 1'b0;
    iprev = 1'b0;
    check_eq({tag, ".fs"}, int'(oFrameStart), 1);
    check_eq({tag, ".pat"}, int'(oPattern), exp_pat);
    check_eq({tag, ".cnt"}, int'(oDwellCnt), exp_cnt);
    check_eq({tag, ".pend"}, int'(oPending), 0);
    ivsync = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
  endtask

  // Mid-frame request pulse of one cycle.
  task automatic pulse(input logic nx, input logic pv, input int exp_pend, input string tag);
    inext = nx;
    iprev = pv;
    @(posedge iclk); #1;
    inext = 1'b0;
    iprev = 1'b0;
    check_eq({tag, ".pend"}, int'(oPending), exp_pend);
  endtask

  initial begin
    int fs_seen;
    irst   = 1'b0;
    ivsync = 1'b0;
    iauto  = 1'b0;
    ihold  = 1'b0;
    inext  = 1'b0;
    iprev  = 1'b0;
    idwell = 10'd3;
    repeat (3) @(posedge iclk);
    #1;
    check_eq("rst.pat", int'(oPattern), 0);
    check_eq("rst.fs", int'(oFrameStart), 0);
    check_eq("rst.cnt", int'(oDwellCnt), 0);
    check_eq("rst.pend", int'(oPending), 0);
    irst = 1'b1;
    repeat (4) @(posedge iclk);
    #1;

    // Auto run, dwell 3; first two boundaries align the sequence to pattern 0.
    iauto = 1'b1;
    frame(1'b0, 1'b1, 7, 0, "auto.align0");
    frame(1'b1, 1'b0, 0, 0, "auto.align1");
    for (int i = 1; i < 10; i++) begin
      frame(1'b0, 1'b0, i / 3, i % 3, $sformatf("auto.f%0d", i));
    end

    // Hold with override.
    ihold = 1'b1;
    frame(1'b0, 1'b0, 3, 1, "hold.enter");
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, 1'b0, 3, 1, $sformatf("hold.f%0d", i));
    end
    pulse(1'b1, 1'b0, 1, "hold.next");
    frame(1'b0, 1'b0, 4, 0, "hold.step");

    // Dwell 0 acts as 1, with wrap.
    ihold  = 1'b0;
    idwell = 10'd0;
    frame(1'b0, 1'b0, 4, 0, "d0.leave_hold");
    frame(1'b0, 1'b0, 5, 0, "d0.f5");
    frame(1'b0, 1'b0, 6, 0, "d0.f6");
    frame(1'b0, 1'b0, 7, 0, "d0.f7");
    frame(1'b0, 1'b0, 0, 0, "d0.wrap");
    frame(1'b0, 1'b0, 1, 0, "d0.f1");

    // Vsync held high over three frame times gives one boundary.
    ivsync  = 1'b1;
    fs_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge iclk); #1;
      if (oFrameStart) fs_seen++;
    end
    check_eq("held.fs_count", fs_seen, 1);
    check_eq("held.pat", int'(oPattern), 2);

    // Reset released with vsync high: no boundary until a low-to-high.
    irst = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    irst    = 1'b1;
    iauto   = 1'b0;
    fs_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge iclk); #1;
      if (oFrameStart) fs_seen++;
    end
    check_eq("rstvs.fs_count", fs_seen, 0);
    check_eq("rstvs.pat", int'(oPattern), 0);
    ivsync = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    frame(1'b0, 1'b0, 0, 1, "rstvs.first");

    // Manual stepping.
    pulse(1'b0, 1'b1, 1, "man.prev");
    frame(1'b0, 1'b0, 7, 0, "man.prev_apply");
    frame(1'b0, 1'b0, 7, 1, "man.count");
    pulse(1'b1, 1'b1, 0, "man.both");
    frame(1'b0, 1'b0, 7, 2, "man.both_apply");
    pulse(1'b1, 1'b0, 1, "man.ow_next");
    pulse(1'b0, 1'b1, 1, "man.ow_prev");
    frame(1'b0, 1'b0, 6, 0, "man.ow_apply");

    // Request coincident with the boundary.
    frame(1'b1, 1'b0, 7, 0, "corner.same_cycle");

    // Reset with a step pending.
    pulse(1'b1, 1'b0, 1, "rstp.next");
    irst = 1'b0;
    @(posedge iclk); #1;
    check_eq("rstp.pat", int'(oPattern), 0);
    check_eq("rstp.pend", int'(oPending), 0);
    check_eq("rstp.cnt", int'(oDwellCnt), 0);
    irst = 1'b1;
    repeat (2) @(posedge iclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
